key_hop_filter: RTL and testbench

- Sits between the USB keyboard keycode register and the frogger game core.
- Turns the raw, level-held 8-bit keycode into debounced one-cycle action pulses: four hop directions plus restart.
- Also produces a debounced show-high-score level and a running hop counter.
- Removes key bounce and host-polling glitches so one press gives exactly one hop.

---
 rtl/frogger_pkg.sv | 29 ++
 rtl/key_timer.sv | 41 ++++
 rtl/key_hop_filter.sv | 174 +++++++++++++++++
 tb/tb_key_hop_filter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// Keycode constants, filter state encoding and keycode classification helpers.
// Pure declarations; no timing. No flow control.
package frogger_pkg;

    localparam logic [7:0] KC_W   = 8'h1A;
    localparam logic [7:0] KC_S   = 8'h16;
    localparam logic [7:0] KC_A   = 8'h04;
    localparam logic [7:0] KC_D   = 8'h07;
    localparam logic [7:0] KC_ESC = 8'h29;
    localparam logic [7:0] KC_H   = 8'h0B;

    typedef enum logic [1:0] {
        IDLE,
        QUAL,
        HELD,
        REPEAT
    } kf_state_t;

    function automatic logic is_mapped(input logic [7:0] kc);
        return (kc == KC_W) || (kc == KC_S) || (kc == KC_A) ||
               (kc == KC_D) || (kc == KC_ESC) || (kc == KC_H);
    endfunction

    // Direction keys are the only ones that move the frog and count as hops.
    function automatic logic is_dir(input logic [7:0] kc);
        return (kc == KC_W) || (kc == KC_S) || (kc == KC_A) || (kc == KC_D);
    endfunction

endpackage

// File: rtl/key_timer.sv
// Loadable up-counter with clear and an equality flag against a compare value.
// Count updates one cycle after clr/load/inc; eq is combinational from the count.
// No flow control.
module key_timer #(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             inc,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] cmp_val,
    output logic             eq
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign eq = (cnt_q == cmp_val);

endmodule

// File: rtl/key_hop_filter.sv
// Debounces a level-held keycode into one-cycle hop/restart pulses, a show-high level
// and a hop counter; pulse lands DEBOUNCE_CYCLES+1 cycles after the key appears.
// No backpressure. Auto-repeat of direction keys under KEY_HOP_FILTER_AUTOREPEAT_EN.
module key_hop_filter
    import frogger_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 20000000,
    parameter int REPEAT_PERIOD   = 7500000,
    parameter int CNT_W           = 25
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    output logic       hop_up,
    output logic       hop_down,
    output logic       hop_left,
    output logic       hop_right,
    output logic       restart,
    output logic       show_high,
    output logic [7:0] hop_count
);

    kf_state_t  state_q, state_d;
    logic [7:0] kc_q;
    logic [7:0] cand_q, cand_d;
    logic       hop_up_q, hop_up_d;
    logic       hop_down_q, hop_down_d;
    logic       hop_left_q, hop_left_d;
    logic       hop_right_q, hop_right_d;
    logic       restart_q, restart_d;
    logic       show_high_q, show_high_d;
    logic [7:0] hop_count_q, hop_count_d;

    logic             tmr_clr, tmr_load, tmr_inc, tmr_eq;
    logic [CNT_W-1:0] tmr_cmp;
    logic             fire;

    key_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .inc      (tmr_inc),
        .load_val (CNT_W'(1)),
        .cmp_val  (tmr_cmp),
        .eq       (tmr_eq)
    );

    // One timer serves every phase; only the terminal count changes with state.
    always_comb begin
        tmr_cmp = CNT_W'(DEBOUNCE_CYCLES - 1);
        case (state_q)
            HELD:    tmr_cmp = CNT_W'(REPEAT_DELAY);
            REPEAT:  tmr_cmp = CNT_W'(REPEAT_PERIOD);
            default: tmr_cmp = CNT_W'(DEBOUNCE_CYCLES - 1);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        tmr_clr  = 1'b0;
        tmr_load = 1'b0;
        tmr_inc  = 1'b0;
        fire     = 1'b0;
        if (state_q != IDLE && kc_q != cand_q) begin
            // A changed code always wins, even on the cycle qualification would finish.
            if (is_mapped(kc_q)) begin
                state_d  = QUAL;
                cand_d   = kc_q;
                tmr_load = 1'b1;
            end else begin
                state_d = IDLE;
                cand_d  = 8'h00;
                tmr_clr = 1'b1;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (is_mapped(kc_q)) begin
                        state_d  = QUAL;
                        cand_d   = kc_q;
                        tmr_load = 1'b1;
                    end
                end
                QUAL: begin
                    if (tmr_eq) begin
                        state_d  = HELD;
                        fire     = 1'b1;
                        tmr_load = 1'b1;
                    end else begin
                        tmr_inc = 1'b1;
                    end
                end
                HELD: begin
`ifdef KEY_HOP_FILTER_AUTOREPEAT_EN
                    if (is_dir(cand_q)) begin
                        if (tmr_eq) begin
                            state_d  = REPEAT;
                            fire     = 1'b1;
                            tmr_load = 1'b1;
                        end else begin
                            tmr_inc = 1'b1;
                        end
                    end
`endif
                end
                REPEAT: begin
`ifdef KEY_HOP_FILTER_AUTOREPEAT_EN
                    if (tmr_eq) begin
                        fire     = 1'b1;
                        tmr_load = 1'b1;
                    end else begin
                        tmr_inc = 1'b1;
                    end
`else
                    state_d = IDLE;
                    cand_d  = 8'h00;
                    tmr_clr = 1'b1;
`endif
                end
            endcase
        end
    end

    always_comb begin
        hop_up_d    = fire && (cand_q == KC_W);
        hop_down_d  = fire && (cand_q == KC_S);
        hop_left_d  = fire && (cand_q == KC_A);
        hop_right_d = fire && (cand_q == KC_D);
        restart_d   = fire && (cand_q == KC_ESC);
        show_high_d = ((state_d == HELD) || (state_d == REPEAT)) && (cand_d == KC_H);
        hop_count_d = hop_count_q;
        if (fire && is_dir(cand_q)) begin
            hop_count_d = hop_count_q + 8'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            kc_q        <= 8'h00;
            cand_q      <= 8'h00;
            hop_up_q    <= 1'b0;
            hop_down_q  <= 1'b0;
            hop_left_q  <= 1'b0;
            hop_right_q <= 1'b0;
            restart_q   <= 1'b0;
            show_high_q <= 1'b0;
            hop_count_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            kc_q        <= keycode;
            cand_q      <= cand_d;
            hop_up_q    <= hop_up_d;
            hop_down_q  <= hop_down_d;
            hop_left_q  <= hop_left_d;
            hop_right_q <= hop_right_d;
            restart_q   <= restart_d;
            show_high_q <= show_high_d;
            hop_count_q <= hop_count_d;
        end
    end

    assign hop_up    = hop_up_q;
    assign hop_down  = hop_down_q;
    assign hop_left  = hop_left_q;
    assign hop_right = hop_right_q;
    assign restart   = restart_q;
    assign show_high = show_high_q;
    assign hop_count = hop_count_q;

endmodule

// File: tb/tb_key_hop_filter.sv
// Bench for key_hop_filter: directed scenarios plus random key sequences checked
// every cycle against a run-length reference model.
module tb_key_hop_filter;

    localparam int DEB  = 4;
    localparam int RDLY = 10;
    localparam int RPER = 5;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [7:0] keycode;
    logic       hop_up, hop_down, hop_left, hop_right, restart, show_high;
    logic [7:0] hop_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: registered keycode, how many consecutive cycles it has held, hop total.
    logic [7:0] m_kcq = 8'h00;
    int         m_run = 0;
    logic [7:0] m_cnt = 8'h00;

    key_hop_filter #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RDLY),
        .REPEAT_PERIOD   (RPER),
        .CNT_W           (8)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .keycode   (keycode),
        .hop_up    (hop_up),
        .hop_down  (hop_down),
        .hop_left  (hop_left),
        .hop_right (hop_right),
        .restart   (restart),
        .show_high (show_high),
        .hop_count (hop_count)
    );

    always #5 Clk = ~Clk;

    function automatic bit m_mapped(input logic [7:0] k);
        return k inside {8'h1A, 8'h16, 8'h04, 8'h07, 8'h29, 8'h0B};
    endfunction

    function automatic bit m_dir(input logic [7:0] k);
        return k inside {8'h1A, 8'h16, 8'h04, 8'h07};
    endfunction

    function automatic bit m_fire(input logic [7:0] k, input int run);
        if (!m_mapped(k)) return 1'b0;
        if (run == DEB) return 1'b1;
`ifdef KEY_HOP_FILTER_AUTOREPEAT_EN
        if (m_dir(k) && run >= DEB + RDLY && ((run - DEB - RDLY) % RPER) == 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [7:0] kc);
        bit f;
        bit e_show;
        keycode = kc;
        f      = m_fire(m_kcq, m_run);
        e_show = (m_kcq == 8'h0B) && (m_run >= DEB);
        if (f && m_dir(m_kcq)) m_cnt = m_cnt + 8'd1;
        @(posedge Clk);
        #1;
        chk("hop_up",    8'(hop_up),    8'(f && m_kcq == 8'h1A));
        chk("hop_down",  8'(hop_down),  8'(f && m_kcq == 8'h16));
        chk("hop_left",  8'(hop_left),  8'(f && m_kcq == 8'h04));
        chk("hop_right", 8'(hop_right), 8'(f && m_kcq == 8'h07));
        chk("restart",   8'(restart),   8'(f && m_kcq == 8'h29));
        chk("show_high", 8'(show_high), 8'(e_show));
        chk("hop_count", hop_count, m_cnt);
        if (m_mapped(kc) && kc == m_kcq) m_run++;
        else if (m_mapped(kc)) m_run = 1;
        else m_run = 0;
        m_kcq = kc;
    endtask

    task automatic hold(input logic [7:0] kc, input int n);
        for (int i = 0; i < n; i++) step(kc);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        #1;
        chk("rst_hop_up",    8'(hop_up),    8'd0);
        chk("rst_hop_down",  8'(hop_down),  8'd0);
        chk("rst_hop_left",  8'(hop_left),  8'd0);
        chk("rst_hop_right", 8'(hop_right), 8'd0);
        chk("rst_restart",   8'(restart),   8'd0);
        chk("rst_show_high", 8'(show_high), 8'd0);
        chk("rst_hop_count", hop_count,     8'd0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        m_kcq = 8'h00;
        m_run = 0;
        m_cnt = 8'h00;
    endtask

    initial begin
        logic [7:0] c0;
        logic [7:0] codes [9];
        codes = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h29, 8'h0B, 8'h00, 8'h55, 8'h1B};
        Reset_n = 1'b0;
        keycode = 8'h00;
        #2;
        do_reset();

        // Single long press of W.
        hold(8'h1A, 30);
        hold(8'h00, 3);
`ifdef KEY_HOP_FILTER_AUTOREPEAT_EN
        chk("s1_count", hop_count, 8'd5);
`else
        chk("s1_count", hop_count, 8'd1);
`endif

        // Bouncy D never qualifies.
        c0 = m_cnt;
        hold(8'h07, 2);
        hold(8'h00, 1);
        hold(8'h07, 3);
        hold(8'h00, 4);
        chk("s2_count", hop_count, c0);

        // Two separate A presses.
        c0 = m_cnt;
        hold(8'h04, 10);
        hold(8'h00, 2);
        hold(8'h04, 10);
        hold(8'h00, 3);
        chk("s3_count", hop_count, c0 + 8'd2);

        // H level then ESC pulse; neither counts as a hop.
        c0 = m_cnt;
        hold(8'h0B, 8);
        hold(8'h00, 3);
        hold(8'h29, 6);
        hold(8'h00, 3);
        chk("s4_count", hop_count, c0);

        // Counter wrap, then reset during a hold and during qualification.
        do_reset();
        repeat (255) begin
            hold(8'h16, 4);
            hold(8'h00, 1);
        end
        chk("s5_count_255", hop_count, 8'd255);
        hold(8'h16, 6);
        hold(8'h00, 2);
        chk("s5_count_wrap", hop_count, 8'd0);
        hold(8'h16, 6);
        hold(8'h0B, 7);
        chk("s5_show_before_rst", 8'(show_high), 8'd1);
        do_reset();
        hold(8'h0B, 3);
        hold(8'h00, 2);
        hold(8'h16, 2);
        do_reset();
        hold(8'h16, 8);
        hold(8'h00, 3);
        chk("s5_requal_count", hop_count, 8'd1);

`ifdef KEY_HOP_FILTER_AUTOREPEAT_EN
        // Auto-repeat of a held direction.
        c0 = m_cnt;
        hold(8'h1A, 40);
        hold(8'h00, 3);
        chk("s6_count", hop_count, c0 + 8'd7);
`endif

        // Random key sequences, including unmapped codes and direct code changes.
        for (int s = 0; s < 80; s++) begin
            hold(codes[$urandom_range(0, 8)], int'($urandom_range(1, 25)));
        end
        hold(8'h00, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
